// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared AHB/APB constants and bridge state encoding
package ahb_apb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_DONE,
      ST_ERR1,
      ST_ERR2
   } bridge_state_t;

endpackage

// File: rtl/apb_wdog.sv
// rtl/apb_wdog.sv - saturating ACCESS-phase watchdog for the AHB-to-APB bridge
module apb_wdog #(
   parameter int TIMEOUT = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic hit
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   // Count stalled ACCESS cycles; hold at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != {CW{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Fires in the TIMEOUT-th ACCESS cycle (count starts at 0 in the first one).
   assign hit = (TIMEOUT != 0) && ((int'(cnt) + 1) >= TIMEOUT);

endmodule

// File: rtl/ahb_apb_bridge.sv
// rtl/ahb_apb_bridge.sv - single-outstanding AHB slave to APB3/APB4 bridge
module ahb_apb_bridge
   import ahb_apb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic                  HWRITE,
   input  logic [1:0]            HTRANS,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  HREADY,
   output logic                  HRESP,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   output logic [3:0]            PSTRB,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   bridge_state_t state;
   logic          accept;
   logic          start;
   logic          wd_hit;
   logic [3:0]    strb_dec;
   logic          unused_burst;

   // Bursts are split into independent single transfers.
   assign unused_burst = ^HBURST;

   assign accept = HSEL && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ)) && HREADY;
   // ERR2 also shows HREADY=1, but its address phase is deliberately dropped.
   assign start  = accept && ((state == ST_IDLE) || (state == ST_DONE));

   // The master holds HWDATA while stalled, so it can be forwarded directly.
   assign PWDATA = PSEL ? HWDATA : '0;

   apb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk   (HCLK),
      .rst_n (HRESETn),
      .clr   (start),
      .en    ((state == ST_ACCESS) && !PREADY),
      .hit   (wd_hit)
   );

   // Byte-lane decode for writes; oversize transfers fall back to a full word.
   always_comb begin
      strb_dec = 4'b1111;
      case (HSIZE)
         HSIZE_BYTE: strb_dec = 4'b0001 << HADDR[1:0];
         HSIZE_HALF: strb_dec = HADDR[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: strb_dec = 4'b1111;
         default:    strb_dec = 4'b1111;
      endcase
   end

   // Bridge sequencer; every AHB/APB control output is registered here.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state   <= ST_IDLE;
         HRDATA  <= '0;
         HREADY  <= 1'b1;
         HRESP   <= HRESP_OKAY;
         PADDR   <= '0;
         PSEL    <= 1'b0;
         PENABLE <= 1'b0;
         PWRITE  <= 1'b0;
         PSTRB   <= 4'b0000;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               HRESP   <= HRESP_OKAY;
               PENABLE <= 1'b0;
               if (start) begin
                  state  <= ST_SETUP;
                  PADDR  <= HADDR;
                  PWRITE <= HWRITE;
                  PSTRB  <= HWRITE ? strb_dec : 4'b0000;
                  PSEL   <= 1'b1;
                  HREADY <= 1'b0;
               end else begin
                  state  <= ST_IDLE;
                  PSEL   <= 1'b0;
                  HREADY <= 1'b1;
               end
            end
            ST_SETUP: begin
               state   <= ST_ACCESS;
               PENABLE <= 1'b1;
            end
            ST_ACCESS: begin
               if (PREADY) begin
                  PSEL    <= 1'b0;
                  PENABLE <= 1'b0;
                  if (PSLVERR) begin
                     state <= ST_ERR1;
                     HRESP <= HRESP_ERROR;
                  end else begin
                     state  <= ST_DONE;
                     HREADY <= 1'b1;
                     if (!PWRITE) begin
                        HRDATA <= PRDATA;
                     end
                  end
               end else if (wd_hit) begin
                  state   <= ST_ERR1;
                  PSEL    <= 1'b0;
                  PENABLE <= 1'b0;
                  HRESP   <= HRESP_ERROR;
               end
            end
            ST_ERR1: begin
               state  <= ST_ERR2;
               HREADY <= 1'b1;
               HRESP  <= HRESP_ERROR;
            end
            ST_ERR2: begin
               state  <= ST_IDLE;
               HREADY <= 1'b1;
               HRESP  <= HRESP_OKAY;
            end
            default: begin
               state   <= ST_IDLE;
               HREADY  <= 1'b1;
               HRESP   <= HRESP_OKAY;
               PSEL    <= 1'b0;
               PENABLE <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb/tb_ahb_apb_bridge.sv - scoreboard testbench for ahb_apb_bridge
module tb_ahb_apb_bridge;
   import ahb_apb_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSEL;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;
   logic [31:0] PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } apb_exp_t;

   typedef struct {
      logic [31:0] rdata;
      logic        resp;
   } rsp_exp_t;

   apb_exp_t    apb_q[$];
   rsp_exp_t    rsp_q[$];
   logic [31:0] last_rdata = 32'h0;
   int          n_cmp = 0;
   int          n_err = 0;

   ahb_apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
      .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .PADDR(PADDR), .PSEL(PSEL),
      .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   initial forever #5 HCLK = ~HCLK;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
      $fatal(1);
   end

   // APB scoreboard: every completed APB access must match the oldest expectation.
   always @(negedge HCLK) begin
      if (HRESETn && PSEL && PENABLE && PREADY) begin
         n_cmp++;
         if (apb_q.size() == 0) begin
            n_err++;
            $display("FAIL apb_unexpected: got access addr=%h, required none", PADDR);
         end else begin
            apb_exp_t e;
            e = apb_q.pop_front();
            if ({PADDR, PWRITE, PWDATA, PSTRB} !== {e.addr, e.wr, e.wdata, e.strb}) begin
               n_err++;
               $display("FAIL apb_access: got addr=%h wr=%b wdata=%h strb=%b, required addr=%h wr=%b wdata=%h strb=%b",
                        PADDR, PWRITE, PWDATA, PSTRB, e.addr, e.wr, e.wdata, e.strb);
            end
         end
      end
   end

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic issue(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic [3:0] strb, input logic [31:0] prdata,
                        input logic err, input bit push_apb, input bit push_rsp);
      apb_exp_t a;
      rsp_exp_t r;
      if (push_apb) begin
         a.addr = addr; a.wr = wr; a.wdata = wdata; a.strb = strb;
         apb_q.push_back(a);
      end
      if (push_rsp) begin
         if (!wr && !err) last_rdata = prdata;
         r.rdata = last_rdata;
         r.resp  = err;
         rsp_q.push_back(r);
      end
      PRDATA = prdata;
      HSEL   = 1'b1;
      HTRANS = HTRANS_NONSEQ;
      HADDR  = addr;
      HWRITE = wr;
      HSIZE  = size;
      HBURST = 3'($urandom_range(0, 7));
   endtask

   task automatic data_phase(input logic [31:0] wdata);
      tick();
      HSEL   = 1'b0;
      HTRANS = HTRANS_IDLE;
      HWDATA = wdata;
      @(negedge HCLK);
   endtask

   // APB completer: answers after 'waits' stalled ACCESS cycles; returns when HREADY rises.
   task automatic run_apb(input int waits, input logic err, output int lows, output int acc,
                          output logic prev_resp, output logic prev_psel, output bit got);
      lows = 0; acc = 0; got = 0; prev_resp = 1'b0; prev_psel = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (HREADY) begin
            got = 1;
            break;
         end
         prev_resp = HRESP;
         prev_psel = PSEL;
         lows++;
         tick();
         if (PSEL && PENABLE) begin
            PREADY  = (acc >= waits);
            PSLVERR = err && PREADY;
            acc++;
         end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
         end
         @(negedge HCLK);
      end
   endtask

   task automatic test_reset();
      HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HTRANS = HTRANS_IDLE;
      HSIZE = HSIZE_WORD; HBURST = 3'b000; HWDATA = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
      @(negedge HCLK);
      n_cmp++;
      if ({HREADY, HRESP, PSEL, PENABLE, PWRITE} !== 5'b10000) begin
         n_err++;
         $display("FAIL reset_ctrl: got HREADY,HRESP,PSEL,PENABLE,PWRITE=%b, required 10000",
                  {HREADY, HRESP, PSEL, PENABLE, PWRITE});
      end
      n_cmp++;
      if ({PADDR, PSTRB, PWDATA, HRDATA} !== 100'h0) begin
         n_err++;
         $display("FAIL reset_data: got PADDR=%h PSTRB=%b PWDATA=%h HRDATA=%h, required all zero",
                  PADDR, PSTRB, PWDATA, HRDATA);
      end
      tick();
      HRESETn = 1'b1;
   endtask

   task automatic test_no_accept();
      for (int i = 0; i < 3; i++) begin
         tick();
         case (i)
            0:       begin HSEL = 1'b1; HTRANS = HTRANS_IDLE; end
            1:       begin HSEL = 1'b1; HTRANS = HTRANS_BUSY; end
            default: begin HSEL = 1'b0; HTRANS = HTRANS_SEQ; end
         endcase
         tick();
         @(negedge HCLK);
         n_cmp++;
         if ({PSEL, HREADY, HRESP} !== 3'b010) begin
            n_err++;
            $display("FAIL no_accept_%0d: got PSEL,HREADY,HRESP=%b, required 010", i, {PSEL, HREADY, HRESP});
         end
      end
      tick();
      HSEL = 1'b0;
      HTRANS = HTRANS_IDLE;
   endtask

   task automatic check_rsp(input string name);
      rsp_exp_t r;
      r = rsp_q.pop_front();
      n_cmp++;
      if (HRESP !== r.resp || HRDATA !== r.rdata) begin
         n_err++;
         $display("FAIL %s_rsp: got HRESP=%b HRDATA=%h, required HRESP=%b HRDATA=%h",
                  name, HRESP, HRDATA, r.resp, r.rdata);
      end
   endtask

   task automatic test_write_word();
      int lows, acc; logic pr, ps; bit got;
      tick();
      issue(32'h10, 1'b1, HSIZE_WORD, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, 1, 1);
      @(negedge HCLK);
      n_cmp++;
      if ({PSEL, HREADY} !== 2'b01) begin
         n_err++;
         $display("FAIL wr_cycle_n: got PSEL,HREADY=%b, required 01", {PSEL, HREADY});
      end
      data_phase(32'hDEADBEEF);
      n_cmp++;
      if ({PSEL, PENABLE, HREADY} !== 3'b100) begin
         n_err++;
         $display("FAIL wr_setup: got PSEL,PENABLE,HREADY=%b, required 100", {PSEL, PENABLE, HREADY});
      end
      run_apb(0, 1'b0, lows, acc, pr, ps, got);
      n_cmp++;
      if (!got || lows != 2 || acc != 1) begin
         n_err++;
         $display("FAIL wr_latency: got ready=%0d low=%0d access=%0d, required ready=1 low=2 access=1", got, lows, acc);
      end
      check_rsp("wr_word");
   endtask

   task automatic test_read_wait();
      int lows, acc; logic pr, ps; bit got;
      tick();
      issue(32'h24, 1'b0, HSIZE_WORD, 32'h0, 4'b0000, 32'h12345678, 1'b0, 1, 1);
      data_phase(32'h0);
      run_apb(3, 1'b0, lows, acc, pr, ps, got);
      n_cmp++;
      if (!got || lows != 5 || acc != 4) begin
         n_err++;
         $display("FAIL rd_wait: got ready=%0d low=%0d access=%0d, required ready=1 low=5 access=4", got, lows, acc);
      end
      check_rsp("rd_wait");
   endtask

   task automatic test_strobes();
      logic [31:0] addrs [5] = '{32'h03, 32'h02, 32'h01, 32'h00, 32'h08};
      logic [2:0]  sizes [5] = '{HSIZE_BYTE, HSIZE_HALF, HSIZE_BYTE, HSIZE_HALF, 3'b011};
      logic [3:0]  strbs [5] = '{4'b1000, 4'b1100, 4'b0010, 4'b0011, 4'b1111};
      int lows, acc; logic pr, ps; bit got;
      logic [31:0] wd;
      for (int i = 0; i < 5; i++) begin
         wd = $urandom;
         tick();
         issue(addrs[i], 1'b1, sizes[i], wd, strbs[i], 32'h0, 1'b0, 1, 1);
         data_phase(wd);
         n_cmp++;
         if (PSTRB !== strbs[i]) begin
            n_err++;
            $display("FAIL strobe_%0d: got PSTRB=%b, required %b", i, PSTRB, strbs[i]);
         end
         run_apb(i % 2, 1'b0, lows, acc, pr, ps, got);
         check_rsp("strobe");
      end
   endtask

   task automatic test_slverr();
      int lows, acc; logic pr, ps; bit got;
      tick();
      issue(32'h30, 1'b0, HSIZE_WORD, 32'h0, 4'b0000, 32'hBAD0BAD0, 1'b1, 1, 1);
      data_phase(32'h0);
      run_apb(0, 1'b1, lows, acc, pr, ps, got);
      n_cmp++;
      if (!got || lows != 3 || pr !== 1'b1) begin
         n_err++;
         $display("FAIL err1: got ready=%0d low=%0d err1_hresp=%b, required ready=1 low=3 err1_hresp=1", got, lows, pr);
      end
      check_rsp("slverr");
      // An address phase shown during ERR2 must be dropped.
      HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = 32'h50; HWRITE = 1'b1;
      tick();
      HSEL = 1'b0; HTRANS = HTRANS_IDLE;
      @(negedge HCLK);
      n_cmp++;
      if ({PSEL, HREADY, HRESP} !== 3'b010) begin
         n_err++;
         $display("FAIL err_idle: got PSEL,HREADY,HRESP=%b, required 010", {PSEL, HREADY, HRESP});
      end
   endtask

   task automatic test_timeout();
      int lows, acc; logic pr, ps; bit got;
      tick();
      issue(32'h60, 1'b0, HSIZE_WORD, 32'h0, 4'b0000, 32'h55AA55AA, 1'b1, 0, 1);
      data_phase(32'h0);
      run_apb(99, 1'b0, lows, acc, pr, ps, got);
      n_cmp++;
      if (!got || lows != 6 || acc != 4 || pr !== 1'b1 || ps !== 1'b0) begin
         n_err++;
         $display("FAIL timeout: got ready=%0d low=%0d access=%0d err1_hresp=%b err1_psel=%b, required 1 6 4 1 0",
                  got, lows, acc, pr, ps);
      end
      check_rsp("timeout");
      tick();
      @(negedge HCLK);
      n_cmp++;
      if ({HREADY, HRESP} !== 2'b10) begin
         n_err++;
         $display("FAIL timeout_idle: got HREADY,HRESP=%b, required 10", {HREADY, HRESP});
      end
   endtask

   task automatic test_back_to_back();
      int lows, acc; logic pr, ps; bit got;
      logic [31:0] rd;
      rd = $urandom;
      tick();
      issue(32'h70, 1'b1, HSIZE_WORD, 32'hA5A5F00F, 4'b1111, 32'h0, 1'b0, 1, 1);
      data_phase(32'hA5A5F00F);
      run_apb(0, 1'b0, lows, acc, pr, ps, got);
      check_rsp("b2b_first");
      issue(32'h74, 1'b0, HSIZE_WORD, 32'h0, 4'b0000, rd, 1'b0, 1, 1);
      data_phase(32'h0);
      n_cmp++;
      if ({PSEL, PENABLE, HREADY} !== 3'b100) begin
         n_err++;
         $display("FAIL b2b_setup: got PSEL,PENABLE,HREADY=%b, required 100", {PSEL, PENABLE, HREADY});
      end
      run_apb(1, 1'b0, lows, acc, pr, ps, got);
      n_cmp++;
      if (!got || lows != 3) begin
         n_err++;
         $display("FAIL b2b_latency: got ready=%0d low=%0d, required ready=1 low=3", got, lows);
      end
      check_rsp("b2b_second");
   endtask

   task automatic test_reset_in_access();
      int lows, acc; logic pr, ps; bit got;
      tick();
      issue(32'h40, 1'b0, HSIZE_WORD, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0, 0, 0);
      data_phase(32'h0);
      tick();
      PREADY = 1'b0;
      n_cmp++;
      if ({PSEL, PENABLE} !== 2'b11) begin
         n_err++;
         $display("FAIL rst_access: got PSEL,PENABLE=%b, required 11", {PSEL, PENABLE});
      end
      #2;
      HRESETn = 1'b0;
      #1;
      n_cmp++;
      if ({PSEL, PENABLE, HREADY, HRDATA} !== {3'b001, 32'h0}) begin
         n_err++;
         $display("FAIL rst_async: got PSEL=%b PENABLE=%b HREADY=%b HRDATA=%h, required 0 0 1 00000000",
                  PSEL, PENABLE, HREADY, HRDATA);
      end
      last_rdata = 32'h0;
      tick();
      HRESETn = 1'b1;
      tick();
      issue(32'h44, 1'b1, HSIZE_HALF, 32'h0BADCAFE, 4'b0011, 32'h0, 1'b0, 1, 1);
      data_phase(32'h0BADCAFE);
      run_apb(0, 1'b0, lows, acc, pr, ps, got);
      check_rsp("post_reset");
   endtask

   initial begin
      test_reset();
      test_no_accept();
      test_write_word();
      test_read_wait();
      test_strobes();
      test_slverr();
      test_timeout();
      test_back_to_back();
      test_reset_in_access();
      n_cmp++;
      if (apb_q.size() != 0 || rsp_q.size() != 0) begin
         n_err++;
         $display("FAIL leftover: got apb=%0d rsp=%0d pending, required 0 0", apb_q.size(), rsp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
